// File: rtl/seq_memory_pkg.sv
// Shared constants and FSM state type for the seq_memory request/response block.
package seq_memory_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_ADDR  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;
endpackage

// File: rtl/seq_memory_array.sv
// Word storage with one write port, one combinational read port and asynchronous clear.
module seq_memory_array
    import seq_memory_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rd_word
);
    localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Per-word registers so the whole array can be cleared asynchronously.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (we && (waddr == ADDR'(gi))) begin
                mem_d[gi] = wdata;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

    // Addresses beyond the populated range read as zero.
    always_comb begin
        rd_word = '0;
        if ({1'b0, raddr} < DEPTH_W) begin
            rd_word = mem_q[raddr];
        end
    end
endmodule

// File: rtl/seq_memory.sv
// Valid/ready handshaked memory: one access per accepted request, one-cycle ready strobe.
module seq_memory
    import seq_memory_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDR-1:0]  addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wrbar,
    output logic [WIDTH-1:0] rdata,
    input  logic             valid,
    output logic             ready
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] rd_word;
    logic             mem_we;

    seq_memory_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (addr),
        .wdata   (wdata),
        .raddr   (addr),
        .rd_word (rd_word)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = RESP;
                    if (wrbar) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Both outputs come straight from flops.
    assign ready = (state_q == RESP);
    assign rdata = rdata_q;
endmodule

// File: tb/tb_seq_memory.sv
// Self-checking bench for seq_memory: directed vector table, hand sequences and random traffic.
module tb_seq_memory;
    localparam int WIDTH    = 32;
    localparam int ADDR     = 8;
    localparam int TB_DEPTH = 240;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [ADDR-1:0]  addr = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic             wrbar = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] rdata;
    logic             ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] ref_mem [256];
    logic [WIDTH-1:0] ref_rdata;

    typedef struct {
        logic             wr;
        logic [ADDR-1:0]  a;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    seq_memory #(
        .WIDTH (WIDTH),
        .DEPTH (TB_DEPTH),
        .ADDR  (ADDR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wrbar (wrbar),
        .rdata (rdata),
        .valid (valid),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_rdata = '0;
    endtask

    // One full transfer: accept, check strobe latency and data, then check the strobe drops.
    task automatic req(input logic wr, input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
        int n;
        @(negedge clk);
        addr  = a;
        wdata = d;
        wrbar = wr;
        valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 8);
        if (wr) begin
            if (int'(a) < TB_DEPTH) ref_mem[a] = d;
        end else begin
            ref_rdata = (int'(a) < TB_DEPTH) ? ref_mem[a] : '0;
        end
        chk("ready_latency", 32'(n), 32'd1);
        chk("rdata", rdata, ref_rdata);
        // Garbage on the inputs during RESP must be ignored.
        addr  = ~a;
        wdata = $urandom;
        wrbar = 1'($urandom);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("ready_pulse_end", {31'd0, ready}, 32'd0);
        chk("rdata_hold", rdata, ref_rdata);
    endtask

    initial begin
        logic [WIDTH-1:0] d0, d2;
        model_clear();

        vecs[0] = '{1'b0, 8'd0,   32'h0,        32'h0};
        vecs[1] = '{1'b0, 8'd255, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 8'd10,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 8'd10,  32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 8'd10,  32'h12345678, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 8'd10,  32'h0,        32'h12345678};
        vecs[6] = '{1'b1, 8'd250, 32'hCAFEF00D, 32'h12345678};
        vecs[7] = '{1'b0, 8'd250, 32'h0,        32'h0};
        vecs[8] = '{1'b1, 8'd239, 32'h0000A5A5, 32'h0};
        vecs[9] = '{1'b0, 8'd239, 32'h0,        32'h0000A5A5};

        #20;
        rst = 1'b1;
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);

        for (int i = 0; i < 10; i++) begin
            req(vecs[i].wr, vecs[i].a, vecs[i].d);
            chk("table_rdata", rdata, vecs[i].exp_rdata);
        end

        for (int a = 0; a < 32; a++) req(1'b1, ADDR'(a), $urandom);
        for (int a = 0; a < 32; a++) req(1'b0, ADDR'(a), '0);
        for (int a = 32; a < 64; a++) req(1'b1, ADDR'(a), $urandom);
        for (int a = 0; a < 64; a++) req(1'b0, ADDR'(a), '0);

        // valid held high for four edges: accept, skip, accept, skip.
        d0 = $urandom;
        d2 = $urandom;
        @(negedge clk);
        addr = 8'd5; wrbar = 1'b1; valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wdata = (k == 0) ? d0 : (k == 2) ? d2 : $urandom;
            chk("stream_ready", {31'd0, ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        valid = 1'b0;
        chk("stream_ready_last", {31'd0, ready}, 32'd0);
        ref_mem[5] = d2;
        req(1'b0, 8'd5, '0);
        chk("stream_mem5", rdata, d2);

        for (int t = 0; t < 200; t++) begin
            req(1'($urandom), ADDR'($urandom_range(0, 255)), $urandom);
        end

        // Reset landing between edges while in RESP.
        req(1'b1, 8'd20, 32'h0BADF00D);
        req(1'b0, 8'd20, '0);
        @(negedge clk);
        addr = 8'd20; wrbar = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("pre_abort_ready", {31'd0, ready}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;
        req(1'b0, 8'd20, '0);
        req(1'b0, 8'd10, '0);
        req(1'b0, 8'd0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
